// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions for the receiver and the transmitter that will
//   join it later.
//   Contents:
//     OVERSAMPLE_DEF  default baud ticks per bit period
//     DATA_BITS_DEF   default data bits per frame
//     uart_state_e    receiver frame-tracking states
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// sync_edge
//   Two-flop synchroniser for an asynchronous input, plus a rising-edge
//   detector on the synchronised value.
//   Ports:
//     clk, reset  system clock, asynchronous active-high reset
//     d           asynchronous input
//     sync        d after two flops
//     rise        one-clk pulse when sync goes 0 -> 1
//   RESET_VAL is the idle level of d, so leaving reset never looks like an
//   edge on a line that is sitting at its idle level.
// -----------------------------------------------------------------------------
module sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic sync,
   output logic rise
);

   logic [1:0] ff_q;
   logic       prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ff_q   <= {2{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         ff_q   <= {ff_q[0], d};
         prev_q <= ff_q[1];
      end
   end

   assign sync = ff_q[1];
   assign rise = ff_q[1] & ~prev_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 (DATA_BITS configurable 5..8) UART receiver driven by a 16x oversample
//   baud square wave. Received bytes are offered to the bus-side register
//   logic over a valid/ready handshake. Framing and overrun errors are sticky.
//   Ports:
//     clk, reset    system clock, asynchronous active-high reset
//     rx_baud_clk   oversample square wave (async); rising edges are ticks
//     rxd           serial line (async), idle high
//     rx_data       received byte, held while rx_valid is high
//     rx_valid      byte available
//     rx_ready      consumer accepts rx_data when rx_valid && rx_ready
//     err_clr       one-cycle pulse that clears both error flags
//     framing_err   sticky: stop bit sampled low
//     overrun_err   sticky: new byte completed while the old one was pending
//     busy          receiver is inside a frame (any state but IDLE)
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int CNT_W      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_baud_clk,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   input  logic                 err_clr,
   output logic                 framing_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int BIT_W = 3;
   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE/2 - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   logic tick;
   logic rxd_s;
   logic baud_sync_unused;
   logic rxd_rise_unused;

   sync_edge #(.RESET_VAL(1'b0)) u_baud_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_baud_clk),
      .sync  (baud_sync_unused),
      .rise  (tick)
   );

   sync_edge #(.RESET_VAL(1'b1)) u_rxd_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rxd),
      .sync  (rxd_s),
      .rise  (rxd_rise_unused)
   );

   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bitn_q, bitn_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 oerr_q, oerr_d;
   logic                 done;       // good stop bit seen this cycle
   logic                 stop_bad;   // stop bit sampled low this cycle
   logic                 accept;

   // Frame tracking. Every state change is gated by tick, so the FSM runs
   // at the oversample rate regardless of the clk frequency.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitn_d   = bitn_q;
      shreg_d  = shreg_q;
      done     = 1'b0;
      stop_bad = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (!rxd_s) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
            START: begin
               // Re-check the line at mid start bit to reject glitches.
               if (cnt_q == MID_CNT) begin
                  cnt_d = '0;
                  if (!rxd_s) begin
                     state_d = DATA;
                     bitn_d  = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DATA: begin
               // Counting from mid start bit, a full bit period lands on
               // mid data bit. Line order is LSB first, so shift right.
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  bitn_d  = bitn_q + 1'b1;
                  shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
                  if (bitn_q == LAST_BIT) state_d = STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d = '0;
                  if (rxd_s) begin
                     done    = 1'b1;
                     state_d = IDLE;
                  end else begin
                     stop_bad = 1'b1;
                     state_d  = WAIT_HIGH;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            WAIT_HIGH: begin
               // Hold off until the line returns high so a break reports
               // one framing error instead of a stream of bogus frames.
               if (rxd_s) state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Delivery and error flags. A completion in the same cycle as an accept
   // simply replaces the byte; only an unaccepted byte being overwritten
   // counts as an overrun. Error sets take priority over err_clr.
   always_comb begin
      accept  = valid_q & rx_ready;
      valid_d = valid_q;
      data_d  = data_q;
      oerr_d  = oerr_q;
      ferr_d  = ferr_q;
      if (accept)  valid_d = 1'b0;
      if (done) begin
         valid_d = 1'b1;
         data_d  = shreg_q;
      end
      if (err_clr) begin
         oerr_d = 1'b0;
         ferr_d = 1'b0;
      end
      if (done && valid_q && !rx_ready) oerr_d = 1'b1;
      if (stop_bad)                     ferr_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bitn_q  <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         oerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bitn_q  <= bitn_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         oerr_q  <= oerr_d;
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign framing_err = ferr_q;
   assign overrun_err = oerr_q;
   assign busy        = (state_q != IDLE);

endmodule
